// File: rtl/uP_pkg.sv
// Shared definitions for the uP datapath: data width and the read-response owner tag.
package uP_pkg;

    localparam int DW = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } rd_owner_t;

endpackage : uP_pkg

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the uP core and the debug port, sitting between
// the decode stage and the RAM. One access per cycle, debug starvation bounded.
module ram_arbiter
    import uP_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 12
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_hold,
    output logic [DW-1:0] core_rdata,

    input  logic          dbg_valid,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_ready,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic          w_starve_hit;
    logic          w_grant_dbg;
    logic          w_grant_core;
    rd_owner_t     w_rd_owner_nxt;

    logic [3:0]    r_starve_cnt;
    rd_owner_t     r_rd_owner;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_dbg_rdata;

    // Grant decision; reset masks both grants so the RAM stays quiet.
    always_comb begin
        w_starve_hit = (r_starve_cnt == STARVE_LIM);
        w_grant_dbg  = rst_n & dbg_valid & (dbg_lock | ~core_req | w_starve_hit);
        w_grant_core = rst_n & core_req & ~w_grant_dbg;
        core_hold    = rst_n & core_req & ~w_grant_core;
        dbg_ready    = w_grant_dbg;
    end

    // Route the granted side onto the RAM port.
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_grant_dbg) begin
            ram_cs    = 1'b1;
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
        end else if (w_grant_core) begin
            ram_cs    = 1'b1;
            ram_we    = core_we;
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
        end else begin
            ram_cs    = 1'b0;
            ram_we    = 1'b0;
        end
    end

    // Tag the owner of this cycle's read so next cycle's RAM data is steered.
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_grant_dbg && !dbg_we) begin
            w_rd_owner_nxt = OWN_DBG;
        end else if (w_grant_core && !core_we) begin
            w_rd_owner_nxt = OWN_CORE;
        end else begin
            w_rd_owner_nxt = OWN_NONE;
        end
    end

    // Debug starvation counter: counts core wins while debug is waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_dbg || !dbg_valid) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_core && (r_starve_cnt < STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Read owner tag plus last-value holding registers for both read paths.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_owner   <= OWN_NONE;
            r_core_rdata <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
            case (r_rd_owner)
                OWN_CORE: r_core_rdata <= ram_rdata;
                OWN_DBG:  r_dbg_rdata  <= ram_rdata;
                default: begin
                    r_core_rdata <= r_core_rdata;
                    r_dbg_rdata  <= r_dbg_rdata;
                end
            endcase
        end
    end

    // RAM data is forwarded in the response cycle; a reset drops any pending response.
    always_comb begin
        core_rdata = r_core_rdata;
        dbg_rdata  = r_dbg_rdata;
        dbg_rvalid = 1'b0;
        if (!rst_n) begin
            dbg_rvalid = 1'b0;
        end else begin
            case (r_rd_owner)
                OWN_CORE: core_rdata = ram_rdata;
                OWN_DBG: begin
                    dbg_rdata  = ram_rdata;
                    dbg_rvalid = 1'b1;
                end
                default: dbg_rvalid = 1'b0;
            endcase
        end
    end

endmodule : ram_arbiter
